// File: rtl/delivery_ctrl_if.sv
// Handshake and status bundle between the delivery controller and the track plant.
// The controller takes the master side; the plant or bench takes the slave side.
interface delivery_ctrl_if #(
  parameter int CW   = 2,
  parameter int CNTW = 8
);
  logic            hall;
  logic [CW-1:0]   object_color;
  logic [CW-1:0]   station_color;
  logic            end_of_track;
  logic            uturn_finished;
  logic            brake_finished;
  logic            reverse_finished;
  logic            fbrake_finished;
  logic            buzz_finished;
  logic            fault_clear;

  logic            en_tracking;
  logic            en_uturn;
  logic            en_brake;
  logic            en_reverse;
  logic            en_fbrake;
  logic            en_buzz;
  logic            en_object;
  logic            en_station;
  logic [3:0]      ssd_state;
  logic [CW-1:0]   active_color;
  logic            fault;
  logic [CNTW-1:0] delivered_cnt;

  modport master (
    input  hall, object_color, station_color, end_of_track, uturn_finished,
           brake_finished, reverse_finished, fbrake_finished, buzz_finished,
           fault_clear,
    output en_tracking, en_uturn, en_brake, en_reverse, en_fbrake, en_buzz,
           en_object, en_station, ssd_state, active_color, fault, delivered_cnt
  );

  modport slave (
    output hall, object_color, station_color, end_of_track, uturn_finished,
           brake_finished, reverse_finished, fbrake_finished, buzz_finished,
           fault_clear,
    input  en_tracking, en_uturn, en_brake, en_reverse, en_fbrake, en_buzz,
           en_object, en_station, ssd_state, active_color, fault, delivered_cnt
  );
endinterface

// File: rtl/delivery_ctrl.sv
// Color-sorting delivery controller: debounced hall detection, one-hot mission FSM,
// per-phase watchdog and delivery counter. All outputs are registered from next state.
module delivery_ctrl #(
  parameter int CW        = 2,
  parameter int DEB       = 16,
  parameter int TMO       = 250000000,
  parameter int CNTW      = 8,
  parameter int RET_UTURN = 1
) (
  input  logic           clk,
  input  logic           rst,
  delivery_ctrl_if.master bus
);

  localparam int WDW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TMO - 1);
  localparam logic [15:0]    DEB_LAST = 16'(DEB - 1);
  localparam logic [15:0]    DEB_SAT  = 16'(DEB);

  localparam logic [9:0] S_READY   = 10'b00_0000_0001;
  localparam logic [9:0] S_NOCOLOR = 10'b00_0000_0010;
  localparam logic [9:0] S_SEND    = 10'b00_0000_0100;
  localparam logic [9:0] S_MATCH   = 10'b00_0000_1000;
  localparam logic [9:0] S_UTURN   = 10'b00_0001_0000;
  localparam logic [9:0] S_RETURN  = 10'b00_0010_0000;
  localparam logic [9:0] S_EOT     = 10'b00_0100_0000;
  localparam logic [9:0] S_REVERSE = 10'b00_1000_0000;
  localparam logic [9:0] S_EOR     = 10'b01_0000_0000;
  localparam logic [9:0] S_FAULT   = 10'b10_0000_0000;
  localparam logic [9:0] TIMED     = S_UTURN | S_REVERSE | S_EOT | S_EOR;

  localparam logic [7:0] EN_TRK = 8'h80;
  localparam logic [7:0] EN_UTN = 8'h40;
  localparam logic [7:0] EN_BRK = 8'h20;
  localparam logic [7:0] EN_REV = 8'h10;
  localparam logic [7:0] EN_FBR = 8'h08;
  localparam logic [7:0] EN_BUZ = 8'h04;
  localparam logic [7:0] EN_OBJ = 8'h02;
  localparam logic [7:0] EN_STN = 8'h01;

  logic [9:0]      state_q, state_d;
  logic [15:0]     deb_q, deb_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            returning_q, returning_d;
  logic [CW-1:0]   color_q, color_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [7:0]      en_q, en_d;
  logic [3:0]      ssd_q, ssd_d;
  logic            fault_q, fault_d;
  logic            det, timed, tmo;

  // Debounce saturates at DEB so a held-low hall fires det only once.
  always_comb begin
    det   = !bus.hall && (deb_q == DEB_LAST);
    deb_d = bus.hall ? '0 : ((deb_q == DEB_SAT) ? deb_q : deb_q + 16'd1);
  end

  always_comb begin
    timed       = (state_q & TIMED) != '0;
    tmo         = timed && (wd_q == WD_LAST);
    state_d     = state_q;
    case (state_q)
      S_READY:   if (det) state_d = (bus.object_color == '0) ? S_NOCOLOR : S_SEND;
      S_NOCOLOR: if (bus.buzz_finished) state_d = S_READY;
      S_SEND: begin
        if (bus.station_color == color_q) state_d = S_MATCH;
        else if (bus.end_of_track)        state_d = S_EOT;
      end
      S_MATCH:   if (det) state_d = S_UTURN;
      S_UTURN: begin
        if (bus.uturn_finished)
          state_d = (returning_q || RET_UTURN == 0) ? S_REVERSE : S_RETURN;
        else if (tmo) state_d = S_FAULT;
      end
      S_RETURN:  if (bus.end_of_track) state_d = S_EOT;
      S_EOT: begin
        if (bus.brake_finished && (bus.buzz_finished || returning_q))
          state_d = (RET_UTURN == 1 || !returning_q) ? S_UTURN : S_REVERSE;
        else if (tmo) state_d = S_FAULT;
      end
      S_REVERSE: begin
        if (bus.reverse_finished) state_d = S_EOR;
        else if (tmo)             state_d = S_FAULT;
      end
      S_EOR: begin
        if (bus.fbrake_finished) state_d = S_READY;
        else if (tmo)            state_d = S_FAULT;
      end
      S_FAULT:   if (bus.fault_clear) state_d = S_READY;
      default:   state_d = S_READY;
    endcase

    wd_d = (state_d != state_q || !timed) ? '0 : wd_q + 1'b1;

    returning_d = returning_q;
    if (state_d == S_READY)       returning_d = 1'b0;
    else if (state_d == S_RETURN) returning_d = 1'b1;

    color_d = color_q;
    if (state_q == S_READY && state_d == S_SEND) color_d = bus.object_color;
    else if (state_d == S_RETURN)                color_d = '0;

    cnt_d = cnt_q;
    if (state_d == S_MATCH && state_q != S_MATCH) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    en_d    = EN_OBJ;
    ssd_d   = 4'd0;
    fault_d = 1'b0;
    case (state_d)
      S_NOCOLOR: begin en_d = EN_BUZ;           ssd_d = 4'd3;  end
      S_SEND:    begin en_d = EN_TRK | EN_STN;  ssd_d = 4'd1;  end
      S_MATCH:   begin en_d = EN_BRK | EN_BUZ;  ssd_d = 4'd2;  end
      S_UTURN:   begin en_d = EN_UTN;           ssd_d = 4'd8;  end
      S_RETURN:  begin en_d = EN_TRK;           ssd_d = 4'd9;  end
      S_EOT:     begin
        en_d  = EN_BRK | (returning_d ? 8'h00 : EN_BUZ);
        ssd_d = 4'd7;
      end
      S_REVERSE: begin en_d = EN_REV;           ssd_d = 4'd10; end
      S_EOR:     begin en_d = EN_FBR;           ssd_d = 4'd11; end
      S_FAULT:   begin en_d = EN_BUZ; ssd_d = 4'd15; fault_d = 1'b1; end
      default:   en_d = EN_OBJ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_READY;
      deb_q       <= '0;
      wd_q        <= '0;
      returning_q <= 1'b0;
      color_q     <= '0;
      cnt_q       <= '0;
      en_q        <= EN_OBJ;
      ssd_q       <= 4'd0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_q       <= deb_d;
      wd_q        <= wd_d;
      returning_q <= returning_d;
      color_q     <= color_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      ssd_q       <= ssd_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.en_tracking   = en_q[7];
  assign bus.en_uturn      = en_q[6];
  assign bus.en_brake      = en_q[5];
  assign bus.en_reverse    = en_q[4];
  assign bus.en_fbrake     = en_q[3];
  assign bus.en_buzz       = en_q[2];
  assign bus.en_object     = en_q[1];
  assign bus.en_station    = en_q[0];
  assign bus.ssd_state     = ssd_q;
  assign bus.active_color  = color_q;
  assign bus.fault         = fault_q;
  assign bus.delivered_cnt = cnt_q;

endmodule
